// File: rtl/wta_pkg.sv
// Shared types and constants for the WTA decision integrator.
// Winner encoding, FSM state encoding and sample field widths.
package wta_pkg;

   localparam int NIBBLE_W = 4;
   localparam int SAMPLE_W = 8;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_A    = 2'b01,
      WIN_B    = 2'b10
   } winner_t;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCUM  = 2'b01,
      REPORT = 2'b10
   } state_t;

endpackage

// File: rtl/wta_sample_classify.sv
// Combinational classifier for one WTA sample.
// in_data -> is_a / is_b / is_bad flags plus both nibble magnitudes.
module wta_sample_classify
   import wta_pkg::*;
(
   input  logic [SAMPLE_W-1:0] in_data,
   output logic                is_a,
   output logic                is_b,
   output logic                is_bad,
   output logic [NIBBLE_W-1:0] mag_a,
   output logic [NIBBLE_W-1:0] mag_b
);

   logic nz_a;
   logic nz_b;

   assign mag_a  = in_data[SAMPLE_W-1:NIBBLE_W];
   assign mag_b  = in_data[NIBBLE_W-1:0];
   assign nz_a   = |mag_a;
   assign nz_b   = |mag_b;

   // Both nibbles active means the WTA stage failed to pick one.
   assign is_a   = nz_a & ~nz_b;
   assign is_b   = nz_b & ~nz_a;
   assign is_bad = nz_a & nz_b;

endmodule

// File: rtl/wta_decision_integrator.sv
// Integrates WTA wins over WINDOW samples and reports one decision per window.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_data sample input,
//   out_valid/out_ready handshake, out_winner, out_cnt_a, out_cnt_b, out_err.
// Build option: WTA_MAG_WEIGHT_EN weights each win by its nibble magnitude.
module wta_decision_integrator
   import wta_pkg::*;
#(
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8,
   parameter int MARGIN = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SAMPLE_W-1:0] in_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [1:0]          out_winner,
   output logic [CNT_W-1:0]    out_cnt_a,
   output logic [CNT_W-1:0]    out_cnt_b,
   output logic                out_err
);

   localparam int SC_W = $clog2(WINDOW + 1);
   localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};
   localparam logic [CNT_W:0] MARG = (CNT_W + 1)'(MARGIN);
   localparam logic [SC_W-1:0] WIN_LAST = SC_W'(WINDOW);

   state_t            state;
   logic [CNT_W-1:0]  cnt_a;
   logic [CNT_W-1:0]  cnt_b;
   logic [SC_W-1:0]   scnt;
   logic              err;
   winner_t           win_q;

   logic              is_a;
   logic              is_b;
   logic              is_bad;
   logic [NIBBLE_W-1:0] mag_a;
   logic [NIBBLE_W-1:0] mag_b;

   logic              acc;
   logic              last;
   logic [CNT_W:0]    inc_a;
   logic [CNT_W:0]    inc_b;
   logic [CNT_W:0]    sum_a;
   logic [CNT_W:0]    sum_b;
   logic [CNT_W-1:0]  nxt_a;
   logic [CNT_W-1:0]  nxt_b;
   logic [SC_W-1:0]   nxt_scnt;
   logic              nxt_err;
   winner_t           nxt_win;

   wta_sample_classify u_classify (
      .in_data (in_data),
      .is_a    (is_a),
      .is_b    (is_b),
      .is_bad  (is_bad),
      .mag_a   (mag_a),
      .mag_b   (mag_b)
   );

   assign in_ready  = (state != REPORT);
   assign out_valid = (state == REPORT);
   assign out_winner = win_q;

   assign acc = in_valid & in_ready;

`ifdef WTA_MAG_WEIGHT_EN
   assign inc_a = is_a ? (CNT_W + 1)'(mag_a) : '0;
   assign inc_b = is_b ? (CNT_W + 1)'(mag_b) : '0;
`else
   logic unused_mag;
   assign unused_mag = ^{mag_a, mag_b};
   assign inc_a = (CNT_W + 1)'(is_a);
   assign inc_b = (CNT_W + 1)'(is_b);
`endif

   // One extra bit catches the carry so the counters clamp, never wrap.
   assign sum_a = {1'b0, cnt_a} + inc_a;
   assign sum_b = {1'b0, cnt_b} + inc_b;
   assign nxt_a = (sum_a > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_a[CNT_W-1:0];
   assign nxt_b = (sum_b > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_b[CNT_W-1:0];

   assign nxt_scnt = scnt + 1'b1;
   assign nxt_err  = err | is_bad;
   assign last     = (nxt_scnt == WIN_LAST);

   // Decision on the post-update counts so the final sample is included.
   always_comb begin
      logic [CNT_W:0] wa;
      logic [CNT_W:0] wb;
      wa = {1'b0, nxt_a};
      wb = {1'b0, nxt_b};
      nxt_win = WIN_NONE;
      if (wa >= wb + MARG) begin
         nxt_win = WIN_A;
      end else if (wb >= wa + MARG) begin
         nxt_win = WIN_B;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt_a     <= '0;
         cnt_b     <= '0;
         scnt      <= '0;
         err       <= 1'b0;
         win_q     <= WIN_NONE;
         out_cnt_a <= '0;
         out_cnt_b <= '0;
         out_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE, ACCUM: begin
               if (acc) begin
                  cnt_a <= nxt_a;
                  cnt_b <= nxt_b;
                  scnt  <= nxt_scnt;
                  err   <= nxt_err;
                  if (last) begin
                     state     <= REPORT;
                     win_q     <= nxt_win;
                     out_cnt_a <= nxt_a;
                     out_cnt_b <= nxt_b;
                     out_err   <= nxt_err;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            REPORT: begin
               if (out_ready) begin
                  state     <= IDLE;
                  cnt_a     <= '0;
                  cnt_b     <= '0;
                  scnt      <= '0;
                  err       <= 1'b0;
                  win_q     <= WIN_NONE;
                  out_cnt_a <= '0;
                  out_cnt_b <= '0;
                  out_err   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wta_decision_integrator.sv
// Self-checking bench for wta_decision_integrator.
// Three instances: WINDOW=4, WINDOW=1 with MARGIN=0, WINDOW=300.
module tb_wta_decision_integrator;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       v4, r4, ov4, ordy4, e4;
   logic [7:0] d4, a4, b4;
   logic [1:0] w4;

   logic       v1, r1, ov1, ordy1, e1;
   logic [7:0] d1, a1, b1;
   logic [1:0] w1;

   logic       vl, rl, ovl, ordyl, el;
   logic [7:0] dl, al, bl;
   logic [1:0] wl;

   wta_decision_integrator #(.WINDOW(4), .CNT_W(8), .MARGIN(2)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v4), .in_ready(r4), .in_data(d4),
      .out_valid(ov4), .out_ready(ordy4),
      .out_winner(w4), .out_cnt_a(a4), .out_cnt_b(b4), .out_err(e4)
   );

   wta_decision_integrator #(.WINDOW(1), .CNT_W(8), .MARGIN(0)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(v1), .in_ready(r1), .in_data(d1),
      .out_valid(ov1), .out_ready(ordy1),
      .out_winner(w1), .out_cnt_a(a1), .out_cnt_b(b1), .out_err(e1)
   );

   wta_decision_integrator #(.WINDOW(300), .CNT_W(8), .MARGIN(2)) dutl (
      .clk(clk), .rst_n(rst_n),
      .in_valid(vl), .in_ready(rl), .in_data(dl),
      .out_valid(ovl), .out_ready(ordyl),
      .out_winner(wl), .out_cnt_a(al), .out_cnt_b(bl), .out_err(el)
   );

   typedef struct packed {
      logic [1:0] w;
      logic [7:0] a;
      logic [7:0] b;
      logic       e;
   } exp_t;

   typedef struct packed {
      logic [3:0][7:0] s;
      exp_t            x;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[6];

   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(logic [7:0] s0, logic [7:0] s1,
                               logic [7:0] s2, logic [7:0] s3,
                               logic [1:0] w, logic [7:0] a,
                               logic [7:0] b, logic e);
      vec_t v;
      v.s[0] = s0;
      v.s[1] = s1;
      v.s[2] = s2;
      v.s[3] = s3;
      v.x.w  = w;
      v.x.a  = a;
      v.x.b  = b;
      v.x.e  = e;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cmp(string tag, logic [1:0] w, logic [7:0] a,
                      logic [7:0] b, logic e);
      exp_t x;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got output expected empty scoreboard", tag);
      end else begin
         x = sb.pop_front();
         chk({tag, ".winner"}, 32'(w), 32'(x.w));
         chk({tag, ".cnt_a"}, 32'(a), 32'(x.a));
         chk({tag, ".cnt_b"}, 32'(b), 32'(x.b));
         chk({tag, ".err"}, 32'(e), 32'(x.e));
      end
   endtask

   task automatic hs4();
      ordy4 = 1'b1;
      @(posedge clk); #1;
      ordy4 = 1'b0;
      chk("hs4.in_ready", 32'(r4), 32'd1);
      chk("hs4.out_valid", 32'(ov4), 32'd0);
   endtask

   task automatic run4(string tag, vec_t v, bit do_hs);
      sb.push_back(v.x);
      for (int i = 0; i < 4; i++) begin
         chk({tag, ".in_ready"}, 32'(r4), 32'd1);
         if (i == 3) chk({tag, ".early_valid"}, 32'(ov4), 32'd0);
         v4 = 1'b1;
         d4 = v.s[i];
         @(posedge clk); #1;
      end
      v4 = 1'b0;
      chk({tag, ".latency"}, 32'(ov4), 32'd1);
      cmp(tag, w4, a4, b4, e4);
      if (do_hs) hs4();
   endtask

   task automatic one1(string tag, logic [7:0] s, exp_t x);
      sb.push_back(x);
      v1 = 1'b1;
      d1 = s;
      @(posedge clk); #1;
      v1 = 1'b0;
      chk({tag, ".latency"}, 32'(ov1), 32'd1);
      cmp(tag, w1, a1, b1, e1);
      ordy1 = 1'b1;
      @(posedge clk); #1;
      ordy1 = 1'b0;
      chk({tag, ".idle"}, 32'(r1), 32'd1);
   endtask

   initial begin
      exp_t x;
      rst_n = 1'b0;
      v4 = 0; d4 = 0; ordy4 = 0;
      v1 = 0; d1 = 0; ordy1 = 0;
      vl = 0; dl = 0; ordyl = 0;

`ifdef WTA_MAG_WEIGHT_EN
      tbl[0] = mk(8'h30, 8'h50, 8'h10, 8'h00, 2'b01, 8'd9, 8'd0, 1'b0);
      tbl[1] = mk(8'h30, 8'h02, 8'h40, 8'h05, 2'b00, 8'd7, 8'd7, 1'b0);
      tbl[2] = mk(8'h33, 8'h03, 8'h07, 8'h01, 2'b10, 8'd0, 8'd11, 1'b1);
      tbl[3] = mk(8'hF0, 8'h0F, 8'h0F, 8'h00, 2'b10, 8'd15, 8'd30, 1'b0);
      tbl[5] = mk(8'h01, 8'h02, 8'h03, 8'h40, 2'b10, 8'd4, 8'd6, 1'b0);
`else
      tbl[0] = mk(8'h30, 8'h50, 8'h10, 8'h00, 2'b01, 8'd3, 8'd0, 1'b0);
      tbl[1] = mk(8'h30, 8'h02, 8'h40, 8'h05, 2'b00, 8'd2, 8'd2, 1'b0);
      tbl[2] = mk(8'h33, 8'h03, 8'h07, 8'h01, 2'b10, 8'd0, 8'd3, 1'b1);
      tbl[3] = mk(8'hF0, 8'h0F, 8'h0F, 8'h00, 2'b00, 8'd1, 8'd2, 1'b0);
      tbl[5] = mk(8'h01, 8'h02, 8'h03, 8'h40, 2'b10, 8'd1, 8'd3, 1'b0);
`endif
      tbl[4] = mk(8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'd0, 8'd0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      chk("rst.out_valid", 32'(ov4), 32'd0);
      chk("rst.in_ready", 32'(r4), 32'd1);
      chk("rst.winner", 32'(w4), 32'd0);
      chk("rst.cnt_a", 32'(a4), 32'd0);
      chk("rst.cnt_b", 32'(b4), 32'd0);
      chk("rst.err", 32'(e4), 32'd0);

      for (int t = 0; t < 6; t++) begin
         run4($sformatf("vec%0d", t), tbl[t], 1'b1);
      end

      // Stall with out_ready low; stray offers must be ignored.
      run4("stall", tbl[0], 1'b0);
      v4 = 1'b1;
      d4 = 8'hF0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("stall.out_valid", 32'(ov4), 32'd1);
         chk("stall.in_ready", 32'(r4), 32'd0);
         chk("stall.winner", 32'(w4), 32'(tbl[0].x.w));
         chk("stall.cnt_a", 32'(a4), 32'(tbl[0].x.a));
      end
      ordy4 = 1'b1;
      @(posedge clk); #1;
      ordy4 = 1'b0;
      v4 = 1'b0;
      chk("release.in_ready", 32'(r4), 32'd1);
      chk("release.out_valid", 32'(ov4), 32'd0);
      run4("after_stall", tbl[1], 1'b1);

      // Reset while a decision is pending.
      run4("pre_rst", tbl[3], 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_rep.out_valid", 32'(ov4), 32'd0);
      chk("rst_rep.in_ready", 32'(r4), 32'd1);
      chk("rst_rep.winner", 32'(w4), 32'd0);
      chk("rst_rep.cnt_a", 32'(a4), 32'd0);
      chk("rst_rep.cnt_b", 32'(b4), 32'd0);

      // Reset mid-window drops the partial counts and err.
      v4 = 1'b1;
      d4 = 8'h33;
      repeat (2) @(posedge clk);
      #1;
      v4 = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_mid.out_valid", 32'(ov4), 32'd0);
      run4("after_rst", tbl[0], 1'b1);

      // WINDOW=1, MARGIN=0: every sample is a decision, ties go to A.
      x = '{w: 2'b01, a: 8'd0, b: 8'd0, e: 1'b0};
      one1("w1_idle", 8'h00, x);
`ifdef WTA_MAG_WEIGHT_EN
      x = '{w: 2'b10, a: 8'd0, b: 8'd15, e: 1'b0};
`else
      x = '{w: 2'b10, a: 8'd0, b: 8'd1, e: 1'b0};
`endif
      one1("w1_b", 8'h0F, x);
      x = '{w: 2'b01, a: 8'd0, b: 8'd0, e: 1'b1};
      one1("w1_bad", 8'h33, x);

      // WINDOW=300: A accumulator clamps at 255.
      sb.push_back('{w: 2'b01, a: 8'd255, b: 8'd0, e: 1'b0});
      vl = 1'b1;
      dl = 8'h10;
      repeat (299) @(posedge clk);
      #1;
      chk("w300.early_valid", 32'(ovl), 32'd0);
      chk("w300.in_ready", 32'(rl), 32'd1);
      @(posedge clk); #1;
      vl = 1'b0;
      chk("w300.latency", 32'(ovl), 32'd1);
      cmp("w300", wl, al, bl, el);

      chk("sb.drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
